// File: rtl/word_serializer_pkg.sv
// word_serializer_pkg: shared widths and FSM encoding for the word serializer
package word_serializer_pkg;
    localparam int WORD_W = 16;
    localparam int SEL_W  = 4;
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/word_serializer_if.sv
// word_serializer_if: parallel-in handshake plus serial-out handshake with framing flags
interface word_serializer_if;
    import word_serializer_pkg::*;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ser_out;
    logic              ser_valid;
    logic              ser_ready;
    logic              ser_first;
    logic              ser_last;
    logic              busy;
    modport master (
        output in_data, in_valid, ser_ready,
        input  in_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );
    modport slave (
        input  in_data, in_valid, ser_ready,
        output in_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );
endinterface

// File: rtl/mux16.sv
// mux16: selects one bit of a 16-bit word
module mux16
    import word_serializer_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    output logic              out
);
    assign out = in[sel];
endmodule

// File: rtl/word_serializer.sv
// word_serializer: holds a 16-bit word and shifts it out one bit per downstream handshake
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input logic              clk,
    input logic              rst,
    word_serializer_if.slave bus
);
    localparam logic [SEL_W-1:0] START = {SEL_W{MSB_FIRST}};
    localparam logic [SEL_W-1:0] STOP  = {SEL_W{!MSB_FIRST}};
    state_t            state;
    logic [SEL_W-1:0]  sel_cnt;
    logic [WORD_W-1:0] data_reg;
    logic              shifting;
    logic              last;
    logic              xfer;
    logic              accept;
    assign shifting      = state == SHIFT;
    assign last          = shifting && sel_cnt == STOP;
    assign xfer          = shifting && bus.ser_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.ser_valid = shifting;
    assign bus.busy      = shifting;
    assign bus.ser_first = shifting && sel_cnt == START;
    assign bus.ser_last  = last;
    // the final transfer frees the register, so a new word can load with no bubble
    assign bus.in_ready  = !shifting || (last && bus.ser_ready);
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel_cnt  <= START;
            data_reg <= '0;
        end else if (accept) begin
            state    <= SHIFT;
            sel_cnt  <= START;
            data_reg <= bus.in_data;
        end else if (xfer) begin
            sel_cnt <= MSB_FIRST ? sel_cnt - 1'b1 : sel_cnt + 1'b1;
            if (last) state <= IDLE;
        end
    end
    mux16 u_mux (
        .in  (data_reg),
        .sel (sel_cnt),
        .out (bus.ser_out)
    );
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed checks of LSB-first and MSB-first serializers driven in lockstep
module tb_word_serializer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        ser_ready = 1'b0;
    logic        pick = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic        o_out, o_valid, o_first, o_last, o_busy, o_in_ready;

    always #5 clk = ~clk;

    word_serializer_if b0();
    word_serializer_if b1();
    assign b0.in_data   = in_data;
    assign b0.in_valid  = in_valid;
    assign b0.ser_ready = ser_ready;
    assign b1.in_data   = in_data;
    assign b1.in_valid  = in_valid;
    assign b1.ser_ready = ser_ready;

    word_serializer #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    word_serializer #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    assign o_out      = pick ? b1.ser_out   : b0.ser_out;
    assign o_valid    = pick ? b1.ser_valid : b0.ser_valid;
    assign o_first    = pick ? b1.ser_first : b0.ser_first;
    assign o_last     = pick ? b1.ser_last  : b0.ser_last;
    assign o_busy     = pick ? b1.busy      : b0.busy;
    assign o_in_ready = pick ? b1.in_ready  : b0.in_ready;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, 16'(o_in_ready), 16'd1);
        check({tag, "_valid"}, 16'(o_valid), 16'd0);
        check({tag, "_busy"}, 16'(o_busy), 16'd0);
        check({tag, "_first"}, 16'(o_first), 16'd0);
        check({tag, "_last"}, 16'(o_last), 16'd0);
    endtask

    task automatic accept(input logic [15:0] w);
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        check("accept_ready", 16'(o_in_ready), 16'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // pat gives ser_ready per cycle; hold cycles must keep showing the same bit
    task automatic run_word(input logic [15:0] w, input logic [3:0] pat, input bit msb);
        int idx;
        logic [3:0] b;
        logic [15:0] word;
        idx  = 0;
        word = w;
        pick = msb;
        for (int c = 0; c < 80 && idx < 16; c++) begin
            ser_ready = pat[c % 4];
            b = msb ? 4'(15 - idx) : 4'(idx);
            @(negedge clk);
            check($sformatf("b%0d_valid", idx), 16'(o_valid), 16'd1);
            check($sformatf("b%0d_busy", idx), 16'(o_busy), 16'd1);
            check($sformatf("b%0d_out", idx), 16'(o_out), 16'(word[b]));
            check($sformatf("b%0d_first", idx), 16'(o_first), 16'(idx == 0));
            check($sformatf("b%0d_last", idx), 16'(o_last), 16'(idx == 15));
            check($sformatf("b%0d_in_ready", idx), 16'(o_in_ready), 16'(idx == 15 && ser_ready));
            if (ser_ready) idx++;
            @(posedge clk);
            #1;
        end
        check("transfers", 16'(idx), 16'd16);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");
        @(negedge clk);
        check("reset_out", 16'(b0.ser_out), 16'd0);

        @(posedge clk);
        #1 ser_ready = 1'b1;
        accept(16'hA5C3);
        run_word(16'hA5C3, 4'b1111, 1'b0);
        ser_ready = 1'b1;
        check_idle("after_single");

        @(posedge clk);
        #1 accept(16'hFFFF);
        in_data  = 16'h0000;
        in_valid = 1'b1;
        run_word(16'hFFFF, 4'b1111, 1'b0);
        in_valid = 1'b0;
        in_data  = 16'hFFFF;
        run_word(16'h0000, 4'b1111, 1'b0);
        check_idle("after_b2b");

        @(posedge clk);
        #1 accept(16'h8001);
        run_word(16'h8001, 4'b1001, 1'b0);
        ser_ready = 1'b1;
        check_idle("after_bp");

        @(posedge clk);
        #1 accept(16'h1234);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        pick = 1'b0;
        check_idle("mid_reset");
        pick = 1'b1;
        check_idle("mid_reset_msb");
        pick = 1'b0;
        @(posedge clk);
        #1 accept(16'h0001);
        run_word(16'h0001, 4'b1111, 1'b0);
        check_idle("after_restart");

        @(posedge clk);
        #1 accept(16'h8000);
        run_word(16'h8000, 4'b1111, 1'b1);
        ser_ready = 1'b1;
        check_idle("after_msb");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
